// File: rtl/rt_axis_pkg.sv
// Shared constants and types for the scene-payload / pixel-stream bridge.
package rt_axis_pkg;

  localparam int DATA_W_DEF       = 32;
  localparam int CFG_WORDS_DEF    = 27;
  localparam int FRAME_PIXELS_DEF = 1024;

  typedef enum logic [1:0] {
    S_RECV   = 2'd0,
    S_FLUSH  = 2'd1,
    S_STREAM = 2'd2
  } state_e;

  // Index width for a counter over n items, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry valid/ready skid buffer; registered output, one beat per cycle sustained.
module axis_skid_buffer #(
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic [1:0][DATA_W-1:0] mem;
  logic                   wr_ptr, rd_ptr;
  logic [1:0]             cnt;
  logic                   push, pop;

  // Ready depends only on occupancy, so no combinational path from out_ready.
  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/axis_frame_bridge.sv
// Captures a fixed-length scene payload from AXIS, kicks the renderer, then
// forwards exactly one frame of pixels to the AXIS master with tlast on the final beat.
module axis_frame_bridge
  import rt_axis_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CFG_WORDS    = CFG_WORDS_DEF,
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEF
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [DATA_W-1:0]           s_axis_tdata,
  input  logic                        s_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [DATA_W-1:0]           m_axis_tdata,
  output logic                        m_axis_tlast,
  output logic [CFG_WORDS*DATA_W-1:0] cfg_words,
  output logic                        cfg_start,
  input  logic                        pix_valid,
  output logic                        pix_ready,
  input  logic [DATA_W-1:0]           pix_data,
  output logic                        frame_done,
  output logic                        cfg_err
);

  localparam int WCW = cnt_w(CFG_WORDS);
  localparam int PCW = cnt_w(FRAME_PIXELS);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(CFG_WORDS - 1);
  localparam logic [PCW-1:0] LAST_PIX  = PCW'(FRAME_PIXELS - 1);

  state_e                             state, state_nxt;
  logic                               live;
  logic [WCW-1:0]                     word_cnt;
  logic [PCW-1:0]                     pix_cnt, adm_cnt;
  logic                               adm_full;
  logic [CFG_WORDS-1:0][DATA_W-1:0]   cfg_q;
  logic [CFG_WORDS-1:0]               cfg_we;
  logic                               s_fire, recv_fire, m_fire, pix_fire;
  logic                               word_last, pay_ok, pay_short, pay_long;
  logic                               flush_end, frame_end, skid_in_ready;

  assign s_fire    = s_axis_tvalid && s_axis_tready;
  assign recv_fire = s_fire && (state == S_RECV);
  assign word_last = (word_cnt == LAST_WORD);
  assign pay_ok    = recv_fire &&  word_last &&  s_axis_tlast;
  assign pay_short = recv_fire && !word_last &&  s_axis_tlast;
  assign pay_long  = recv_fire &&  word_last && !s_axis_tlast;
  assign flush_end = s_fire && (state == S_FLUSH) && s_axis_tlast;
  assign m_fire    = m_axis_tvalid && m_axis_tready;
  assign frame_end = m_fire && (pix_cnt == LAST_PIX);
  assign pix_fire  = pix_valid && pix_ready;

  assign m_axis_tlast = m_axis_tvalid && (pix_cnt == LAST_PIX);
  assign cfg_words    = cfg_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= S_RECV;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RECV: begin
        if (pay_ok)        state_nxt = S_STREAM;
        else if (pay_long) state_nxt = S_FLUSH;
      end
      S_FLUSH:  if (flush_end) state_nxt = S_RECV;
      S_STREAM: if (frame_end) state_nxt = S_RECV;
      default:  state_nxt = S_RECV;
    endcase
  end

  // live keeps s_axis_tready low throughout reset; it rises on the first edge after.
  always_comb begin
    s_axis_tready = 1'b0;
    pix_ready     = 1'b0;
    case (state)
      S_RECV, S_FLUSH: s_axis_tready = live;
      S_STREAM:        pix_ready     = skid_in_ready && !adm_full;
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      live       <= 1'b0;
      word_cnt   <= '0;
      cfg_start  <= 1'b0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      live       <= 1'b1;
      cfg_start  <= pay_ok;
      frame_done <= frame_end;
      cfg_err    <= cfg_err || pay_short || pay_long;
      if (pay_ok || pay_short || pay_long || flush_end) word_cnt <= '0;
      else if (recv_fire)                               word_cnt <= word_cnt + 1'b1;
    end
  end

  // pix_cnt tracks beats leaving; adm_cnt/adm_full cap what the renderer may push.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pix_cnt  <= '0;
      adm_cnt  <= '0;
      adm_full <= 1'b0;
    end else begin
      if (frame_end)   pix_cnt <= '0;
      else if (m_fire) pix_cnt <= pix_cnt + 1'b1;
      if (frame_end) begin
        adm_cnt  <= '0;
        adm_full <= 1'b0;
      end else if (pix_fire) begin
        if (adm_cnt == LAST_PIX) adm_full <= 1'b1;
        else                     adm_cnt  <= adm_cnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < CFG_WORDS; i++) begin : g_cfg_we
    assign cfg_we[i] = recv_fire && (word_cnt == WCW'(i));
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cfg_q <= '0;
    end else begin
      for (int i = 0; i < CFG_WORDS; i++)
        if (cfg_we[i]) cfg_q[i] <= s_axis_tdata;
    end
  end

  axis_skid_buffer #(.DATA_W(DATA_W)) u_skid (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_valid  (pix_valid && pix_ready),
    .in_ready  (skid_in_ready),
    .in_data   (pix_data),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready),
    .out_data  (m_axis_tdata)
  );

endmodule

// File: tb/tb_axis_frame_bridge.sv
// Directed + randomized bench for axis_frame_bridge with a queue-based frame model.
module tb_axis_frame_bridge;
  import rt_axis_pkg::*;

  localparam int DW = DATA_W_DEF;
  localparam int CW = CFG_WORDS_DEF;
  localparam int NP = FRAME_PIXELS_DEF;
  localparam int VW = DW * CW;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b1;
  logic          s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          m_axis_tvalid, m_axis_tready = 1'b0, m_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [VW-1:0] cfg_words;
  logic          cfg_start, frame_done, cfg_err;
  logic          pix_valid = 1'b0, pix_ready;
  logic [DW-1:0] pix_data = '0;

  int checks = 0, errors = 0;
  int n_start = 0;
  logic [DW-1:0] pay[$];

  always #5 aclk = ~aclk;
  always @(posedge aclk) if (cfg_start) n_start++;

  axis_frame_bridge dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .cfg_words(cfg_words), .cfg_start(cfg_start),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .frame_done(frame_done), .cfg_err(cfg_err)
  );

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [VW-1:0] pack_pay();
    logic [VW-1:0] v = '0;
    for (int i = 0; i < CW; i++) v[i*DW +: DW] = pay[i];
    return v;
  endfunction

  task automatic do_reset();
    pix_valid = 1'b0; m_axis_tready = 1'b0; s_axis_tvalid = 1'b0;
    aresetn = 1'b0;
    #1;
    chk("rst_m_valid", m_axis_tvalid, 1'b0);
    chk("rst_m_last", m_axis_tlast, 1'b0);
    chk("rst_m_data", m_axis_tdata, '0);
    chk("rst_s_ready", s_axis_tready, 1'b0);
    chk("rst_pix_ready", pix_ready, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_cfg_words", cfg_words, '0);
    repeat (3) tick();
    chk("rst_hold_m_valid", m_axis_tvalid, 1'b0);
    chk("rst_hold_s_ready", s_axis_tready, 1'b0);
    aresetn = 1'b1;
    tick();
    chk("post_rst_s_ready", s_axis_tready, 1'b1);
  endtask

  // Drives the words in pay; tlast on index last_at (-1 for none).
  task automatic send(input int last_at);
    for (int i = 0; i < pay.size(); i++) begin
      s_axis_tvalid = 1'b0;
      repeat ($urandom_range(0, 1)) tick();
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = pay[i];
      s_axis_tlast  = (i == last_at);
      chk("s_ready_recv", s_axis_tready, 1'b1);
      tick();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic good_payload(input bit ramp);
    int s0;
    pay.delete();
    for (int i = 0; i < CW; i++) pay.push_back(ramp ? DW'(i) : DW'($urandom));
    s0 = n_start;
    send(CW - 1);
    chk("cfg_start_pulse", cfg_start, 1'b1);
    chk("s_ready_stream", s_axis_tready, 1'b0);
    chk("cfg_words", cfg_words, pack_pay());
    tick();
    chk("cfg_start_low", cfg_start, 1'b0);
    chk("cfg_start_once", n_start - s0, 1);
  endtask

  task automatic bad_payload(input int n, input int last_at);
    int s0;
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(DW'($urandom));
    s0 = n_start;
    send(last_at);
    repeat (3) tick();
    chk("bad_cfg_err", cfg_err, 1'b1);
    chk("bad_no_start", n_start - s0, 0);
    chk("bad_back_recv", s_axis_tready, 1'b1);
  endtask

  // Frame model: admitted pixels queue in order; every output beat pops one.
  task automatic run_frame(input bit full, input int stop_at);
    logic [DW-1:0] q[$];
    logic [DW-1:0] nxt, stall_data, want;
    int adm, outn, cyc, last_cyc;
    bit stall, last_prev, fin;
    adm = 0; outn = 0; cyc = 0; last_cyc = -1;
    stall = 1'b0; last_prev = 1'b0; fin = 1'b0;
    stall_data = '0;
    nxt = DW'($urandom);
    while (!fin && cyc < 20000) begin
      if (last_prev) begin
        chk("frame_done_pulse", frame_done, 1'b1);
        chk("end_pix_ready", pix_ready, 1'b0);
        chk("end_s_ready", s_axis_tready, 1'b1);
        fin = 1'b1;
      end else begin
        pix_valid     = full ? 1'b1 : 1'($urandom_range(0, 1));
        pix_data      = nxt;
        m_axis_tready = full ? 1'b1 : 1'($urandom_range(0, 1));
        chk("frame_done_idle", frame_done, 1'b0);
        if (adm == NP) chk("no_excess_admit", pix_ready, 1'b0);
        else if (full) chk("full_rate_ready", pix_ready, 1'b1);
        if (stall) begin
          chk("stall_valid", m_axis_tvalid, 1'b1);
          chk("stall_data", m_axis_tdata, stall_data);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          chk("beat_backed", q.size() != 0, 1'b1);
          if (q.size() != 0) begin
            want = q.pop_front();
            chk("m_data", m_axis_tdata, want);
          end
          chk("m_last", m_axis_tlast, outn == NP - 1);
          if (outn == NP - 1) last_cyc = cyc;
          outn++;
        end
        last_prev = (m_axis_tvalid && m_axis_tready && outn == NP);
        if (pix_valid && pix_ready) begin
          q.push_back(pix_data);
          adm++;
          nxt = DW'($urandom);
        end
        stall      = m_axis_tvalid && !m_axis_tready;
        stall_data = m_axis_tdata;
        if (stop_at < NP && outn >= stop_at) fin = 1'b1;
      end
      tick();
      cyc++;
    end
    pix_valid = 1'b0;
    chk("frame_finished", fin, 1'b1);
    if (full && stop_at >= NP) chk("full_rate_tlast_cycle", last_cyc, NP);
  endtask

  initial begin
    #2;
    do_reset();

    // Ramp payload then a full-rate frame.
    good_payload(1'b1);
    chk("cfg_word26", cfg_words[26*DW +: DW], DW'(32'h1A));
    chk("cfg_err_clean", cfg_err, 1'b0);
    run_frame(1'b1, NP);

    // Random payload, random backpressure and pixel gaps.
    good_payload(1'b0);
    run_frame(1'b0, NP);

    // Early tlast, then a correct payload recovers.
    bad_payload(11, 10);
    good_payload(1'b0);
    chk("err_sticky", cfg_err, 1'b1);
    run_frame(1'b0, NP);

    // Overlong payload flushes back to receive.
    bad_payload(30, 29);
    good_payload(1'b0);
    run_frame(1'b0, NP);

    // Reset part-way through a frame, then a clean payload and frame.
    good_payload(1'b0);
    run_frame(1'b0, 500);
    do_reset();
    good_payload(1'b0);
    chk("post_rst_err", cfg_err, 1'b0);
    run_frame(1'b0, NP);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_frame_bridge.md
AXIS_FRAME_BRIDGE -- requirements
Module: axis_frame_bridge

Interface
REQ-001 Parameter DATA_W, default 32, word width of all streams.
REQ-002 Parameter CFG_WORDS, default 27, scene payload length in words.
REQ-003 Parameter FRAME_PIXELS, default 1024 (32x32), pixels per frame.
REQ-004 aclk  in  1  single clock; every register is on its rising edge.
REQ-005 aresetn  in  1  reset, asynchronous assert, active-low.
REQ-006 s_axis_tvalid / s_axis_tready / s_axis_tdata / s_axis_tlast  in / out / in / in  1 / 1 / DATA_W / 1  AXIS slave for the scene payload.
REQ-007 m_axis_tvalid / m_axis_tready / m_axis_tdata / m_axis_tlast  out / in / out / out  1 / 1 / DATA_W / 1  AXIS master for the pixel stream.
REQ-008 cfg_words  out  CFG_WORDS*DATA_W  captured payload; word i occupies bits [i*DATA_W +: DATA_W].
REQ-009 cfg_start  out  1  one-cycle pulse: payload complete, start rendering.
REQ-010 pix_valid / pix_ready / pix_data  in / out / in  1 / 1 / DATA_W  pixel input from the renderer, valid/ready.
REQ-011 frame_done  out  1  one-cycle pulse after the last pixel is accepted downstream.
REQ-012 cfg_err  out  1  sticky framing-error flag.

Function
REQ-013 The FSM SHALL have states S_RECV, S_FLUSH and S_STREAM.
REQ-014 A beat SHALL transfer only on a cycle where valid and ready are both high, on either port.
REQ-015 In S_RECV, s_axis_tready SHALL be 1, and each accepted beat SHALL write cfg_words[word_cnt] and increment word_cnt.
REQ-016 Beat index CFG_WORDS-1 accepted with tlast=1 SHALL cause these actions on the next edge: enter S_STREAM, pulse cfg_start, clear word_cnt.
REQ-017 tlast=1 on any beat with index below CFG_WORDS-1 SHALL set cfg_err, clear word_cnt and remain in S_RECV, with cfg_start not pulsed.
REQ-018 Beat index CFG_WORDS-1 without tlast SHALL set cfg_err and enter S_FLUSH.
REQ-019 S_FLUSH SHALL hold s_axis_tready=1, discard beats, and return to S_RECV with word_cnt=0 after a beat with tlast=1.
REQ-020 In S_STREAM, s_axis_tready SHALL be 0, and cfg_words SHALL stay stable until the next complete payload.
REQ-021 Pixels SHALL pass through a 2-entry skid buffer; pix_ready SHALL be 1 when a buffer entry is free and the state is S_STREAM, and 0 otherwise.
REQ-022 Latency SHALL be 1 cycle from a pix accept to m_axis_tvalid; sustained throughput with m_axis_tready held high SHALL be 1 pixel/cycle.
REQ-023 m_axis_tdata and m_axis_tvalid SHALL remain stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-024 pix_cnt SHALL count accepted m_axis beats from 0 to FRAME_PIXELS-1.
REQ-025 m_axis_tlast SHALL be 1 exactly on the beat where pix_cnt==FRAME_PIXELS-1.
REQ-026 After the tlast beat is accepted, the block SHALL pulse frame_done, clear pix_cnt and enter S_RECV.
REQ-027 pix_ready SHALL stop admitting pixels once FRAME_PIXELS have been admitted in the current frame, so excess pixels are never accepted.
REQ-028 A simultaneous skid push and pop SHALL keep the occupancy unchanged, with no loss or reordering.
REQ-029 cfg_err SHALL clear only on reset.

Reset
REQ-030 While aresetn=0, the block SHALL hold state=S_RECV, all counters 0, skid empty, cfg_words 0 and cfg_err 0.
REQ-031 While aresetn=0, every output SHALL be 0, including s_axis_tready.
REQ-032 On the first edge after release, s_axis_tready SHALL be 1.
REQ-033 Reset mid-frame SHALL discard buffered pixels and any partial payload, with no tlast emitted.

Structure
REQ-034 Package rt_axis_pkg SHALL hold CFG_WORDS_DEF=27, FRAME_PIXELS_DEF=1024, DATA_W_DEF=32 and the state enum type.
REQ-035 The skid buffer SHALL be sub-module axis_skid_buffer (DATA_W parameter, valid/ready on both sides).
REQ-036 Counter widths SHALL be $clog2 of CFG_WORDS and FRAME_PIXELS.

Verification
REQ-037 Scenario: 27 words 0x00..0x1A, tlast on the 27th -> cfg_start pulses once, cfg_words word 26 = 0x1A, cfg_err=0.
REQ-038 Scenario: pixels 0..1023 with m_axis_tready=1 -> 1024 in-order beats, tlast only on beat 1023, frame_done one cycle after it.
REQ-039 Scenario: random m_axis_tready (50%) and random pix_valid -> no loss, duplication or reordering, and outputs stable while stalled.
REQ-040 Scenario: tlast on word 10 -> cfg_err=1, no cfg_start, then a correct 27-word payload -> cfg_start pulses.
REQ-041 Scenario: 30 words with tlast on the 30th -> cfg_err=1, flush, state returns to S_RECV with no cfg_start.
REQ-042 Scenario: aresetn low after pixel 500 -> m_axis_tvalid=0 and s_axis_tready=0 during reset, then a fresh payload and frame complete correctly.
